shifter_input_deser: RTL
========================

// Module: shifter_input_deser
// PURPOSE
//  Receive end of the shift-chain error serial link. Samples the 1-bit serial stream that carries
//  SHIFT_ERROR0 then SHIFT_ERROR1, each 12 bits LSB first, 24-bit frames back to back on DATA_CLK.
//  Rebuilds both counts and presents them as parallel words with a one-cycle valid strobe. Sits on
//  the capture side of the test fixture and feeds the host readout logic.
// PARAMETERS
//  WORD_W    12  bits per error word
//  NUM_WORDS 2   words per frame (word 0 = SHIFT_ERROR0, word 1 = SHIFT_ERROR1)
//  FCNT_W    16  width of received-frame counter
// PORTS
//  DATA_CLK        in   1                  link bit clock, all logic on rising edge
//  RST             in   1                  asynchronous, active-low reset
//  DATA_IN         in   1                  serial data, one bit per DATA_CLK
//  SYNC            in   1                  high in the cycle DATA_IN carries bit 0 of word 0
//  SHIFT_ERROR0_RX out  WORD_W             last complete word 0
//  SHIFT_ERROR1_RX out  WORD_W             last complete word 1
//  FRAME_VALID     out  1                  one-cycle pulse: new frame on *_RX outputs
//  LOCKED          out  1                  framer aligned, receiving frames
//  SYNC_ERROR      out  1                  sticky: SYNC seen off a frame boundary
//  FRAME_COUNT     out  FCNT_W             complete frames received, saturating
// BEHAVIOUR
//  - Reset (RST=0, async): all outputs 0, shift register 0, bit index 0, state HUNT.
//  - States: HUNT (wait for SYNC), RECV (collecting). No other states.
//  - HUNT: DATA_IN ignored until an edge with SYNC=1. That edge samples DATA_IN as frame bit 0.
//    Bit index goes to 1. State goes to RECV.
//  - RECV: each edge samples DATA_IN into frame bit[idx] and increments idx.
//    Bits 0..11 go to word 0 bit 0..11. Bits 12..23 go to word 1 bit 0..11.
//  - Last bit (idx = WORD_W*NUM_WORDS-1 = 23): on the same edge, *_RX outputs load the assembled
//    words including this bit. FRAME_VALID goes 1 for exactly the next cycle. LOCKED goes 1.
//    FRAME_COUNT increments, holding at all-ones. idx wraps to 0 and the state stays RECV.
//  - Free-running: after the first frame, frames follow back to back without needing SYNC.
//    SYNC=1 at idx 0 is accepted silently.
//  - SYNC=1 in RECV at idx != 0:
//    - The partial frame is discarded and no FRAME_VALID is raised.
//    - That edge's DATA_IN is taken as bit 0 of a new frame, and idx goes to 1.
//    - SYNC_ERROR is set and stays set until reset. LOCKED clears until the next complete frame.
//  - *_RX outputs hold between frames. Partially received bits never appear on them.
//  - Reset mid-frame: partial data is lost, the block returns to HUNT, and the outputs clear.
//  - Latency: last bit sampled on edge N means *_RX are valid and FRAME_VALID=1 after edge N.
// STRUCTURE
//  - Shared package holds FRAME_W = WORD_W*NUM_WORDS and the HUNT/RECV state encoding.
//    The transmitter uses the same package so frame length cannot diverge.
//  - One sub-module, shifter_frame_counter: bit index counter with wrap at FRAME_W-1, a sync-restart
//    input, and a last-bit flag. Shift register, output latches and status flags stay in the top.
// TESTING
//  - Reset, DATA_IN toggling, SYNC=0 for 50 cycles -> FRAME_VALID never 1, LOCKED=0, *_RX=0.
//  - SYNC then frame with word0=12'hA5C, word1=12'h3F1, LSB first
//    -> one pulse after bit 23, RX0=A5C, RX1=3F1, LOCKED=1, FRAME_COUNT=1.
//  - Three back-to-back frames, SYNC only on the first (000/FFF, 001/800, 7FF/555)
//    -> 3 pulses 24 cycles apart, correct words each time, FRAME_COUNT=3.
//  - SYNC reasserted at idx 10 mid-frame, then a full frame 123/456
//    -> no pulse for the partial frame, SYNC_ERROR=1, then RX0=123, RX1=456.
//  - RST low at idx 17 of a frame, then a fresh SYNC and frame ABC/DEF
//    -> outputs 0 during reset, then one pulse with RX0=ABC, RX1=DEF, FRAME_COUNT=1.
//  - Force FRAME_COUNT near max (FCNT_W=4, 16+ frames) -> counter holds at 4'hF, frames still decode.

Source files
------------

// File: rtl/shifter_input_deser_pkg.sv
// Shared definitions for the shift-chain error serial link.
// The transmitter imports the same package, so both ends agree on the
// frame length and the framer state encoding.
package shifter_input_deser_pkg;

  localparam int WORD_W_DEF    = 12;  // bits per error word
  localparam int NUM_WORDS_DEF = 2;   // words per frame
  localparam int FCNT_W_DEF    = 16;  // received-frame counter width
  localparam int FRAME_W       = WORD_W_DEF * NUM_WORDS_DEF;

  typedef enum logic {
    ST_HUNT = 1'b0,  // waiting for SYNC
    ST_RECV = 1'b1   // collecting frame bits
  } state_e;

  // Width of a bit index that can address every bit of a frame.
  function automatic int idx_w(input int frame_w);
    return (frame_w > 1) ? $clog2(frame_w) : 1;
  endfunction

endpackage

// File: rtl/shifter_input_deser_if.sv
// Link/readout bundle of the shift-chain error deserializer.
//   slave  : deserializer side (takes DATA_IN/SYNC, drives readout outputs)
//   master : fixture side (drives DATA_IN/SYNC, observes readout outputs)
interface shifter_input_deser_if #(
  parameter int WORD_W = 12,
  parameter int FCNT_W = 16
);
  logic              DATA_IN;
  logic              SYNC;
  logic [WORD_W-1:0] SHIFT_ERROR0_RX;
  logic [WORD_W-1:0] SHIFT_ERROR1_RX;
  logic              FRAME_VALID;
  logic              LOCKED;
  logic              SYNC_ERROR;
  logic [FCNT_W-1:0] FRAME_COUNT;

  modport slave (
    input  DATA_IN, SYNC,
    output SHIFT_ERROR0_RX, SHIFT_ERROR1_RX, FRAME_VALID, LOCKED,
           SYNC_ERROR, FRAME_COUNT
  );

  modport master (
    output DATA_IN, SYNC,
    input  SHIFT_ERROR0_RX, SHIFT_ERROR1_RX, FRAME_VALID, LOCKED,
           SYNC_ERROR, FRAME_COUNT
  );
endinterface

// File: rtl/shifter_input_deser_frame_counter.sv
// Frame bit index counter.
//   clk, rst_n : clock, async active-low reset
//   adv        : step the index this edge (framer is receiving)
//   restart    : SYNC seen; this edge holds bit 0, so the index goes to 1
//   idx        : index of the bit sampled on the coming edge
//   last       : this edge samples the final bit of a frame (not on restart)
module shifter_frame_counter
  import shifter_input_deser_pkg::*;
#(
  parameter int FW    = FRAME_W,
  parameter int IDX_W = idx_w(FW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             restart,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             at_end;

  assign at_end = (idx_q == IDX_W'(FW - 1));

  always_comb begin
    idx_d = idx_q;
    if (restart)  idx_d = IDX_W'(1);
    else if (adv) idx_d = at_end ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx  = idx_q;
  assign last = adv && !restart && at_end;

endmodule

// File: rtl/shifter_input_deser.sv
// Receive end of the shift-chain error serial link.
// Rebuilds SHIFT_ERROR0/SHIFT_ERROR1 (LSB first, word 0 first) from a
// 1-bit stream and presents them with a one-cycle FRAME_VALID strobe.
//   DATA_CLK : bit clock, everything on the rising edge
//   RST      : async active-low reset
//   link     : DATA_IN/SYNC in; RX words, FRAME_VALID, LOCKED,
//              SYNC_ERROR (sticky), FRAME_COUNT (saturating) out
module shifter_input_deser
  import shifter_input_deser_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int FCNT_W    = FCNT_W_DEF
) (
  input  logic                 DATA_CLK,
  input  logic                 RST,
  shifter_input_deser_if.slave link
);

  localparam int FW    = WORD_W * NUM_WORDS;
  localparam int IDX_W = idx_w(FW);

  logic             clk, rst_n;
  assign clk   = DATA_CLK;
  assign rst_n = RST;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic             last, adv, restart, in_recv, sync_err_evt;

  logic [FW-1:0]     sh_q, sh_d;
  logic [WORD_W-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
  logic              fv_q, fv_d, lock_q, lock_d, serr_q, serr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  // ---- FSM: next state (RECV is free-running once entered) ----
  always_comb begin
    state_d = state_q;
    if (state_q == ST_HUNT && link.SYNC) state_d = ST_RECV;
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_recv = (state_q == ST_RECV);
    adv     = in_recv;
    restart = link.SYNC;
  end

  shifter_frame_counter #(.FW(FW), .IDX_W(IDX_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (adv),
    .restart (restart),
    .idx     (idx),
    .last    (last)
  );

  // SYNC at idx 0 is simply the expected frame start; anywhere else it
  // means the previous partial frame was misaligned.
  assign sync_err_evt = in_recv && link.SYNC && (idx != '0);

  always_comb begin
    sh_d = sh_q;
    if (link.SYNC) begin
      sh_d    = '0;
      sh_d[0] = link.DATA_IN;
    end else if (in_recv) begin
      sh_d[idx] = link.DATA_IN;
    end

    // Load from sh_d so the final bit sampled this edge is included.
    rx0_d = rx0_q;
    rx1_d = rx1_q;
    if (last) begin
      rx0_d = sh_d[WORD_W-1:0];
      rx1_d = sh_d[2*WORD_W-1:WORD_W];
    end

    fv_d = last;

    lock_d = lock_q;
    if (last)              lock_d = 1'b1;
    else if (sync_err_evt) lock_d = 1'b0;

    serr_d = serr_q | sync_err_evt;

    fcnt_d = fcnt_q;
    if (last && (fcnt_q != '1)) fcnt_d = fcnt_q + FCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rx0_q  <= '0;
      rx1_q  <= '0;
      fv_q   <= 1'b0;
      lock_q <= 1'b0;
      serr_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      sh_q   <= sh_d;
      rx0_q  <= rx0_d;
      rx1_q  <= rx1_d;
      fv_q   <= fv_d;
      lock_q <= lock_d;
      serr_q <= serr_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign link.SHIFT_ERROR0_RX = rx0_q;
  assign link.SHIFT_ERROR1_RX = rx1_q;
  assign link.FRAME_VALID     = fv_q;
  assign link.LOCKED          = lock_q;
  assign link.SYNC_ERROR      = serr_q;
  assign link.FRAME_COUNT     = fcnt_q;

endmodule
